// File: rtl/cache_req_ctrl.sv
// Cache request controller: CPU request/response handshake around a one-shot cache access.
// Optional WAIT timeout enabled by defining CACHE_REQ_TIMEOUT_EN.
module cache_req_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_WAIT   = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  re,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  done
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
        $error("MAX_WAIT out of range 1..255");
    end

    state_t                  state_q;
    logic                    req_ready_q;
    logic                    resp_valid_q;
    logic [DATA_WIDTH-1:0]   resp_rdata_q;
    logic                    resp_err_q;
    logic                    re_q;
    logic                    we_q;
    logic                    held_we_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wr_data_q;

`ifdef CACHE_REQ_TIMEOUT_EN
    logic [7:0] cnt_q;
    logic       timeout_d;

    // Fires in the MAX_WAIT-th WAIT cycle still lacking done.
    assign timeout_d = (cnt_q == 8'(MAX_WAIT - 1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            re_q         <= 1'b0;
            we_q         <= 1'b0;
            held_we_q    <= 1'b0;
            addr_q       <= '0;
            wr_data_q    <= '0;
`ifdef CACHE_REQ_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            re_q <= 1'b0;
            we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        held_we_q   <= req_we;
                        addr_q      <= req_addr;
                        wr_data_q   <= req_wdata;
                        re_q        <= ~req_we;
                        we_q        <= req_we;
                        req_ready_q <= 1'b0;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
`ifdef CACHE_REQ_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                end
                WAIT: begin
                    if (done) begin
                        resp_rdata_q <= held_we_q ? '0 : rd_data;
                        resp_err_q   <= 1'b0;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
`ifdef CACHE_REQ_TIMEOUT_EN
                    end else if (timeout_d) begin
                        resp_rdata_q <= '0;
                        resp_err_q   <= 1'b1;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
`endif
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign re         = re_q;
    assign we         = we_q;
    assign addr       = addr_q;
    assign wr_data    = wr_data_q;

endmodule

// File: tb/tb_cache_req_ctrl.sv
// Scoreboard bench for cache_req_ctrl: expected responses queued at stimulus,
// popped by a monitor on each response handshake.
module tb_cache_req_ctrl;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;
    logic          re;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data;
    logic          done;

    int checks = 0;
    int errors = 0;

    logic [DW:0] sb[$];
    logic [DW:0] exp_q;

    cache_req_ctrl #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .MAX_WAIT  (15)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err),
        .re        (re),
        .we        (we),
        .addr      (addr),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Monitor: strobe exclusivity every cycle, scoreboard on handshakes.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            checks++;
            if ((re & we) !== 1'b0) begin
                errors++;
                $display("FAIL strobe_excl re=%b we=%b required not both", re, we);
            end
        end
        if (resp_valid === 1'b1 && resp_ready === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected got rdata=%h err=%b required none",
                         resp_rdata, resp_err);
            end else begin
                exp_q = sb.pop_front();
                if ({resp_err, resp_rdata} !== exp_q) begin
                    errors++;
                    $display("FAIL resp_data got err=%b rdata=%h required err=%b rdata=%h",
                             resp_err, resp_rdata, exp_q[DW], exp_q[DW-1:0]);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_hs got ready=%b valid=%b required 1 0", req_ready, resp_valid);
        end
        checks++;
        if (resp_rdata !== 8'h00 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_resp got rdata=%h err=%b required 00 0", resp_rdata, resp_err);
        end
        checks++;
        if (re !== 1'b0 || we !== 1'b0 || addr !== 8'h00 || wr_data !== 8'h00) begin
            errors++;
            $display("FAIL rst_cache got re=%b we=%b addr=%h wd=%h required 0 0 00 00",
                     re, we, addr, wr_data);
        end
    endtask

    task automatic test_read();
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 8'h3C;
        req_wdata = 8'h00;
        sb.push_back({1'b0, 8'hA5});
        cyc();
        req_valid = 1'b0;
        checks++;
        if (re !== 1'b1 || we !== 1'b0 || addr !== 8'h3C || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL rd_issue got re=%b we=%b addr=%h rdy=%b required 1 0 3c 0",
                     re, we, addr, req_ready);
        end
        cyc();
        checks++;
        if (re !== 1'b0) begin
            errors++;
            $display("FAIL rd_one_cycle got re=%b required 0", re);
        end
        repeat (2) cyc();
        done    = 1'b1;
        rd_data = 8'hA5;
        cyc();
        done    = 1'b0;
        rd_data = 8'h00;
        checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 8'hA5 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL rd_resp got v=%b rdata=%h err=%b required 1 a5 0",
                     resp_valid, resp_rdata, resp_err);
        end
        cyc();
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rd_idle got v=%b rdy=%b required 0 1", resp_valid, req_ready);
        end
    endtask

    task automatic test_write();
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 8'h10;
        req_wdata = 8'h5A;
        sb.push_back({1'b0, 8'h00});
        cyc();
        req_valid = 1'b0;
        checks++;
        if (we !== 1'b1 || re !== 1'b0 || wr_data !== 8'h5A || addr !== 8'h10) begin
            errors++;
            $display("FAIL wr_issue got we=%b re=%b wd=%h addr=%h required 1 0 5a 10",
                     we, re, wr_data, addr);
        end
        cyc();
        checks++;
        if (we !== 1'b0) begin
            errors++;
            $display("FAIL wr_one_cycle got we=%b required 0", we);
        end
        done    = 1'b1;
        rd_data = 8'hEE;
        cyc();
        done    = 1'b0;
        rd_data = 8'h00;
        checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 8'h00) begin
            errors++;
            $display("FAIL wr_resp got v=%b rdata=%h required 1 00", resp_valid, resp_rdata);
        end
        cyc();
    endtask

    task automatic test_backpressure();
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_addr   = 8'h44;
        sb.push_back({1'b0, 8'hC3});
        cyc();
        req_valid = 1'b0;
        cyc();
        done    = 1'b1;
        rd_data = 8'hC3;
        cyc();
        rd_data   = 8'h11;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 8'h99;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== 8'hC3 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d] got v=%b rdata=%h rdy=%b required 1 c3 0",
                         i, resp_valid, resp_rdata, req_ready);
            end
            cyc();
        end
        done      = 1'b0;
        req_valid = 1'b0;
        checks++;
        if (addr !== 8'h44 || resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_nocap got addr=%h v=%b required 44 1", addr, resp_valid);
        end
        resp_ready = 1'b1;
        cyc();
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release got v=%b rdy=%b required 0 1", resp_valid, req_ready);
        end
    endtask

    task automatic test_reset_in_wait();
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 8'h5D;
        cyc();
        req_valid = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || addr !== 8'h00 || re !== 1'b0) begin
            errors++;
            $display("FAIL rstw_state got rdy=%b v=%b addr=%h re=%b required 1 0 00 0",
                     req_ready, resp_valid, addr, re);
        end
        done    = 1'b1;
        rd_data = 8'hFF;
        cyc();
        done = 1'b0;
        cyc();
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstw_done got v=%b rdy=%b required 0 1", resp_valid, req_ready);
        end
    endtask

    task automatic test_spurious_done();
        done    = 1'b1;
        rd_data = 8'h42;
        repeat (2) cyc();
        done = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || re !== 1'b0 || resp_rdata !== 8'h00) begin
            errors++;
            $display("FAIL spur_done got rdy=%b v=%b re=%b rdata=%h required 1 0 0 00",
                     req_ready, resp_valid, re, resp_rdata);
        end
    endtask

    task automatic test_back_to_back();
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 8'h21;
        sb.push_back({1'b0, 8'h77});
        cyc();
        req_valid = 1'b0;
        cyc();
        done    = 1'b1;
        rd_data = 8'h77;
        cyc();
        done      = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 8'h22;
        req_wdata = 8'h99;
        sb.push_back({1'b0, 8'h00});
        cyc();
        checks++;
        if (req_ready !== 1'b1 || we !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle got rdy=%b we=%b required 1 0", req_ready, we);
        end
        cyc();
        req_valid = 1'b0;
        checks++;
        if (we !== 1'b1 || addr !== 8'h22 || wr_data !== 8'h99) begin
            errors++;
            $display("FAIL b2b_issue got we=%b addr=%h wd=%h required 1 22 99",
                     we, addr, wr_data);
        end
        cyc();
        done = 1'b1;
        cyc();
        done = 1'b0;
        cyc();
    endtask

`ifdef CACHE_REQ_TIMEOUT_EN
    task automatic test_timeout();
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 8'h66;
        cyc();
        req_valid = 1'b0;
        repeat (15) cyc();
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL to_early got v=%b required 0", resp_valid);
        end
        sb.push_back({1'b1, 8'h00});
        cyc();
        checks++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b1) begin
            errors++;
            $display("FAIL to_fire got v=%b err=%b required 1 1", resp_valid, resp_err);
        end
        cyc();
        req_valid = 1'b1;
        cyc();
        req_valid = 1'b0;
        repeat (15) cyc();
        done    = 1'b1;
        rd_data = 8'h3C;
        sb.push_back({1'b0, 8'h3C});
        cyc();
        done = 1'b0;
        checks++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL to_done_wins got v=%b err=%b required 1 0", resp_valid, resp_err);
        end
        cyc();
    endtask
`endif

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b1;
        rd_data    = '0;
        done       = 1'b0;
        test_reset();
        test_spurious_done();
        test_read();
        test_write();
        test_backpressure();
        test_reset_in_wait();
        test_back_to_back();
`ifdef CACHE_REQ_TIMEOUT_EN
        test_timeout();
`endif
        repeat (3) cyc();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d pending required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
